// File: rtl/bp_me_cce_req_scheduler.sv
// Arbitrates several LCE request sources onto one CCE request port: round-robin
// selection, a grant lock under backpressure, in-flight accounting and busy/error status.
module bp_me_cce_req_scheduler #(
  parameter int num_req_p         = 2,
  parameter int header_width_p    = 64,
  parameter int max_outstanding_p = 1,
  parameter int busy_cnt_width_p  = 32,
  localparam int src_width_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int out_width_lp     = $clog2(max_outstanding_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p*header_width_p-1:0] req_header_i,
  input  logic [num_req_p-1:0]                req_v_i,
  output logic [num_req_p-1:0]                req_ready_and_o,
  output logic [header_width_p-1:0]           cce_header_o,
  output logic                                cce_v_o,
  input  logic                                cce_ready_and_i,
  output logic [src_width_lp-1:0]             cce_src_o,
  input  logic                                done_i,
  output logic                                start_o,
  output logic                                end_o,
  output logic [out_width_lp-1:0]             outstanding_o,
  output logic [busy_cnt_width_p-1:0]         busy_cycles_o,
  output logic                                err_o,
  output logic                                lock_state_o
);

  typedef enum logic {
    e_unlocked = 1'b0,
    e_locked   = 1'b1
  } lock_state_e;

  // Handshake contract: a transfer happens on a cycle where valid & ready are both
  // high; valid never depends combinationally on ready, and once raised toward the
  // CCE the selected source and header hold until that transfer (or the requester drops).

  lock_state_e                  lock_state_r;
  logic [src_width_lp-1:0]      lock_idx_r;
  logic [src_width_lp-1:0]      rr_ptr_r;
  logic [out_width_lp-1:0]      outstanding_r;
  logic [busy_cnt_width_p-1:0]  busy_r;
  logic                         err_r;

  logic [src_width_lp-1:0]      sel_idx;
  logic [src_width_lp-1:0]      rr_next;
  logic                         sel_v;
  logic                         lock_drop;
  logic                         slot_avail;
  logic                         handshake;
  logic                         spurious_done;
  int                           cand;

  always_comb begin
    sel_idx   = rr_ptr_r;
    sel_v     = 1'b0;
    lock_drop = 1'b0;
    cand      = 0;
    if (lock_state_r == e_locked) begin
      sel_idx   = lock_idx_r;
      sel_v     = req_v_i[lock_idx_r];
      lock_drop = ~req_v_i[lock_idx_r];
    end else begin
      // Walk offsets downward so the nearest valid source at or after rr_ptr wins.
      for (int i = num_req_p - 1; i >= 0; i--) begin
        cand = (int'(rr_ptr_r) + i) % num_req_p;
        if (req_v_i[cand]) begin
          sel_idx = src_width_lp'(cand);
          sel_v   = 1'b1;
        end
      end
    end
  end

  assign slot_avail    = (outstanding_r < out_width_lp'(max_outstanding_p));
  assign cce_v_o       = ~reset_i & slot_avail & sel_v;
  assign handshake     = cce_v_o & cce_ready_and_i;
  assign start_o       = handshake;
  assign end_o         = ~reset_i & done_i & (outstanding_r != '0);
  assign spurious_done = done_i & (outstanding_r == '0);
  assign cce_src_o     = sel_idx;
  assign cce_header_o  = req_header_i[sel_idx*header_width_p +: header_width_p];
  assign rr_next       = (sel_idx == src_width_lp'(num_req_p - 1)) ? '0 : sel_idx + 1'b1;

  always_comb begin
    req_ready_and_o = '0;
    for (int k = 0; k < num_req_p; k++) begin
      req_ready_and_o[k] = handshake & (sel_idx == src_width_lp'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_state_r  <= e_unlocked;
      lock_idx_r    <= '0;
      rr_ptr_r      <= '0;
      outstanding_r <= '0;
      busy_r        <= '0;
      err_r         <= 1'b0;
    end else begin
      case (lock_state_r)
        e_unlocked: begin
          if (cce_v_o & ~cce_ready_and_i) begin
            lock_state_r <= e_locked;
            lock_idx_r   <= sel_idx;
          end
        end
        e_locked: begin
          if (handshake | lock_drop) lock_state_r <= e_unlocked;
        end
        default: lock_state_r <= e_unlocked;
      endcase

      if (handshake) rr_ptr_r <= rr_next;

      // A completion only frees a slot for the next cycle; no same-cycle bypass.
      case ({handshake, end_o})
        2'b10:   outstanding_r <= outstanding_r + 1'b1;
        2'b01:   outstanding_r <= outstanding_r - 1'b1;
        default: outstanding_r <= outstanding_r;
      endcase

      if ((outstanding_r != '0) && (busy_r != '1)) busy_r <= busy_r + 1'b1;

      if (spurious_done | lock_drop) err_r <= 1'b1;
    end
  end

  assign outstanding_o = outstanding_r;
  assign busy_cycles_o = busy_r;
  assign err_o         = err_r;
  assign lock_state_o  = (lock_state_r == e_locked);

endmodule

// File: tb/tb_bp_me_cce_req_scheduler.sv
// Bench for bp_me_cce_req_scheduler: directed scenarios plus random traffic,
// checked against a transaction-level reference model through expected queues.
module tb_bp_me_cce_req_scheduler;
  localparam int N    = 3;
  localparam int HW   = 16;
  localparam int MAXO = 2;
  localparam int BW   = 4;
  localparam int SW   = 2;
  localparam int OW   = 2;
  localparam int W    = SW + HW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i = 1'b1;
  logic [N*HW-1:0]   req_header_i = '0;
  logic [N-1:0]      req_v_i = '0;
  logic [N-1:0]      req_ready_and_o;
  logic [HW-1:0]     cce_header_o;
  logic              cce_v_o;
  logic              cce_ready_and_i = 1'b0;
  logic [SW-1:0]     cce_src_o;
  logic              done_i = 1'b0;
  logic              start_o;
  logic              end_o;
  logic [OW-1:0]     outstanding_o;
  logic [BW-1:0]     busy_cycles_o;
  logic              err_o;
  logic              lock_state_o;

  bp_me_cce_req_scheduler #(
    .num_req_p(N), .header_width_p(HW), .max_outstanding_p(MAXO), .busy_cnt_width_p(BW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .req_header_i(req_header_i), .req_v_i(req_v_i),
    .req_ready_and_o(req_ready_and_o), .cce_header_o(cce_header_o), .cce_v_o(cce_v_o),
    .cce_ready_and_i(cce_ready_and_i), .cce_src_o(cce_src_o), .done_i(done_i),
    .start_o(start_o), .end_o(end_o), .outstanding_o(outstanding_o),
    .busy_cycles_o(busy_cycles_o), .err_o(err_o), .lock_state_o(lock_state_o)
  );

  typedef struct {
    logic [N-1:0]  rdy;
    logic          cv, st, en, err;
    logic [OW-1:0] outs;
    logic [BW-1:0] busy;
    logic [SW-1:0] src;
    logic [HW-1:0] hdr;
  } stat_t;

  stat_t         st_q[$];
  logic [W-1:0]  exp_q[$];
  int            n_vec = 0;
  int            n_fail = 0;

  // reference model state, kept as plain integers
  int m_rr = 0, m_lidx = 0, m_out = 0, m_busy = 0;
  bit m_lock = 0, m_err = 0;

  // requester state: pending flag and header per source
  bit            pend[N];
  logic [HW-1:0] hdr[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, predict the outputs, advance the model
  task automatic step(input bit rst, input bit rdy, input bit done);
    stat_t e;
    int sel;
    bit selv, drop, avail, cv, hs, en;
    @(posedge clk); #1;
    reset_i = rst; cce_ready_and_i = rdy; done_i = done;
    for (int s = 0; s < N; s++) begin
      req_v_i[s] = pend[s];
      req_header_i[s*HW +: HW] = hdr[s];
    end
    e.outs = OW'(m_out); e.busy = BW'(m_busy); e.err = m_err;
    e.rdy = '0; e.src = '0; e.hdr = '0;
    if (rst) begin
      e.cv = 0; e.st = 0; e.en = 0;
      st_q.push_back(e);
      m_rr = 0; m_lidx = 0; m_out = 0; m_busy = 0; m_lock = 0; m_err = 0;
      return;
    end
    sel = m_rr; selv = 0; drop = 0;
    avail = (m_out < MAXO);
    if (m_lock) begin
      sel = m_lidx; selv = pend[sel]; drop = !selv;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!selv && pend[(m_rr + k) % N]) begin
          sel = (m_rr + k) % N; selv = 1;
        end
      end
    end
    cv = avail && selv;
    hs = cv && rdy;
    en = done && (m_out > 0);
    e.cv = cv; e.st = hs; e.en = en;
    e.src = SW'(sel); e.hdr = hdr[sel];
    if (hs) e.rdy[sel] = 1'b1;
    st_q.push_back(e);
    if (hs) exp_q.push_back({SW'(sel), hdr[sel]});
    if ((done && m_out == 0) || (m_lock && drop)) m_err = 1;
    if (hs) m_lock = 0;
    else if (cv) begin m_lock = 1; m_lidx = sel; end
    else if (m_lock && drop) m_lock = 0;
    if (hs) m_rr = (sel + 1) % N;
    if (m_out > 0 && m_busy < (1 << BW) - 1) m_busy++;
    m_out = m_out + int'(hs) - int'(en);
    if (hs) pend[sel] = 0;
  endtask

  task automatic request(input int s);
    pend[s] = 1;
    hdr[s] = HW'($urandom);
  endtask

  task automatic drain();
    for (int s = 0; s < N; s++) pend[s] = 0;
    repeat (5) step(0, 1, m_out > 0);
  endtask

  // scoreboard monitor, sampling away from the active edge
  always @(negedge clk) begin
    stat_t e;
    logic [W-1:0] x;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("cce_v", 32'(cce_v_o), 32'(e.cv));
      chk("start", 32'(start_o), 32'(e.st));
      chk("end", 32'(end_o), 32'(e.en));
      chk("req_ready", 32'(req_ready_and_o), 32'(e.rdy));
      chk("outstanding", 32'(outstanding_o), 32'(e.outs));
      chk("busy_cycles", 32'(busy_cycles_o), 32'(e.busy));
      chk("err", 32'(err_o), 32'(e.err));
      if (e.cv) begin
        chk("cce_src", 32'(cce_src_o), 32'(e.src));
        chk("cce_header", 32'(cce_header_o), 32'(e.hdr));
      end
    end
    if (start_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL hs_unexpected: got src %0d hdr %0h expected no handshake", cce_src_o, cce_header_o);
      end else begin
        x = exp_q.pop_front();
        chk("hs_order", 32'({cce_src_o, cce_header_o}), 32'(x));
      end
    end
  end

  initial begin
    bit d;
    for (int s = 0; s < N; s++) begin pend[s] = 0; hdr[s] = '0; end
    repeat (3) step(1, 0, 0);

    // both sources, always ready, done one cycle after each grant
    for (int c = 0; c < 10; c++) begin
      d = (m_out > 0) && (c > 0);
      if (!pend[0]) request(0);
      if (!pend[1]) request(1);
      step(0, 1, d);
    end
    drain();

    // source 1 held under backpressure while source 0 arrives
    request(1); step(0, 0, 0);
    request(0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 1, 0);
    drain();

    // outstanding limit: three requests, no completions, then one done
    request(0); request(1); request(2);
    repeat (3) step(0, 1, 0);
    step(0, 1, 1);
    repeat (2) step(0, 1, 0);
    drain();

    // spurious done sets a sticky error
    repeat (2) step(1, 0, 0);
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);

    // busy counter saturation
    step(1, 0, 0);
    request(2); step(0, 1, 0);
    repeat (20) step(0, 0, 0);
    drain();

    // reset with one in flight and a locked grant, then a stale done
    step(1, 0, 0);
    request(0); step(0, 1, 0);
    request(1); step(0, 0, 0);
    step(1, 0, 0);
    for (int s = 0; s < N; s++) pend[s] = 0;
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // random traffic
    step(1, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!pend[s] && $urandom_range(0, 3) == 0) request(s);
        else if (pend[s] && $urandom_range(0, 31) == 0) pend[s] = 0;
      end
      if ($urandom_range(0, 499) == 0) step(1, 0, 0);
      else step(0, $urandom_range(0, 3) != 0,
                (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0));
    end
    drain();
    step(0, 0, 0);
    @(negedge clk); #1;
    chk("status_queue_left", st_q.size(), 0);
    chk("handshake_queue_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
